// File: rtl/button_debouncer.sv
// Multi-bit push-button / switch debouncer.
// Each input bit is synchronised into the clk domain and then filtered by its
// own counter: the output bit only takes a new level after the synchronised
// input has disagreed with it for MAX_COUNT consecutive cycles.
module button_debouncer #(
  parameter int WIDTH       = 4,
  parameter int MAX_COUNT   = 100000,
  parameter int SYNC_STAGES = 2       // must be >= 2 for metastability protection
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataSource,
  output logic [WIDTH-1:0] dataDebounced
);

  // A one-cycle window still needs a 1-bit counter so the vectors stay legal.
  localparam int              CNT_W    = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: raw pins shift through SYNC_STAGES flops per bit.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single stage.
    if (reset) begin
      // NOTE: these are a handful of discrete flops, not a RAM, so clearing
      // them in a reset loop is cheap and keeps the post-reset state defined.
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= dataSource;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Per-bit filter: count cycles of disagreement, accept the level on the last one.
  always_comb begin
    // NOTE: every output of this block gets a default first; without it a bit
    // whose branch does not assign would hold its value and infer a latch.
    out_d = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == out_q[i]) begin
        cnt_d[i] = '0;                       // agreement (or a bounce back) restarts the window
      end else if (cnt_q[i] == CNT_LAST) begin
        out_d[i] = sync_s[i];                // window complete: take the new level
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);     // stops at CNT_LAST, so it never wraps
      end
    end
  end

  // Counter and output registers; reset overrides any count in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      out_q <= out_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dataDebounced = out_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer.
// Two instances share clk/reset: a 4-bit one with a 32-cycle window for the
// main scenarios and a 1-bit one with a 4-cycle window for the short-run case.
// The reference model tracks, per bit, the cycle at which the delayed input
// began to disagree with the accepted level.
module tb_button_debouncer;

  localparam int W     = 4;
  localparam int S     = 2;
  localparam int MAX_A = 32;
  localparam int MAX_B = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] src_a;
  logic [W-1:0] deb_a;
  logic [0:0]   src_b;
  logic [0:0]   deb_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  button_debouncer #(.WIDTH(W), .MAX_COUNT(MAX_A), .SYNC_STAGES(S)) dut_a (
    .clk(clk), .reset(reset), .dataSource(src_a), .dataDebounced(deb_a)
  );

  button_debouncer #(.WIDTH(1), .MAX_COUNT(MAX_B), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .reset(reset), .dataSource(src_b), .dataDebounced(deb_b)
  );

  // ---------------- reference model ----------------
  int         cyc = 0;
  logic [W-1:0] pipe_a [S];
  logic         pipe_b [S];
  logic [W-1:0] exp_a = '0;
  logic         exp_b = 1'b0;
  int           start_a [W];
  int           start_b = -1;

  function automatic void model_step();
    logic [W-1:0] s_a;
    logic         s_b;
    cyc++;
    if (reset) begin
      for (int k = 0; k < S; k++) begin
        pipe_a[k] = '0;
        pipe_b[k] = 1'b0;
      end
      exp_a = '0;
      exp_b = 1'b0;
      for (int i = 0; i < W; i++) start_a[i] = -1;
      start_b = -1;
    end else begin
      s_a = pipe_a[S-1];
      s_b = pipe_b[S-1];
      for (int i = 0; i < W; i++) begin
        if (s_a[i] == exp_a[i]) start_a[i] = -1;
        else begin
          if (start_a[i] < 0) start_a[i] = cyc;
          if (cyc - start_a[i] + 1 >= MAX_A) begin
            exp_a[i]   = s_a[i];
            start_a[i] = -1;
          end
        end
      end
      if (s_b == exp_b) start_b = -1;
      else begin
        if (start_b < 0) start_b = cyc;
        if (cyc - start_b + 1 >= MAX_B) begin
          exp_b   = s_b;
          start_b = -1;
        end
      end
      for (int k = S - 1; k > 0; k--) begin
        pipe_a[k] = pipe_a[k-1];
        pipe_b[k] = pipe_b[k-1];
      end
      pipe_a[0] = src_a;
      pipe_b[0] = src_b[0];
    end
  endfunction

  // One clock: model follows the rising edge, outputs are then read at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    src_a = '0;
    src_b = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (deb_a !== 4'h0) $display("FAIL reset_a got=%h exp=0", deb_a); else n_pass++;
    n_checks++;
    if (deb_b !== 1'b0) $display("FAIL reset_b got=%h exp=0", deb_b); else n_pass++;
    for (int n = 0; n < 8; n++) begin
      tick();
      n_checks++;
      if ({deb_a, deb_b} !== {exp_a, exp_b})
        $display("FAIL reset_idle n=%0d got=%h exp=%h", n, {deb_a, deb_b}, {exp_a, exp_b});
      else n_pass++;
    end
  endtask

  task automatic test_rise_latency();
    int lat = 0;
    src_a = 4'h1;
    for (int n = 1; n <= 2 * MAX_A + S; n++) begin
      tick();
      if (deb_a[0] === 1'b1 && lat == 0) lat = n;
      n_checks++;
      if (deb_a !== exp_a) $display("FAIL rise n=%0d got=%h exp=%h", n, deb_a, exp_a);
      else n_pass++;
    end
    n_checks++;
    if (lat != S + MAX_A) $display("FAIL rise_latency got=%0d exp=%0d", lat, S + MAX_A);
    else n_pass++;
    n_checks++;
    if (deb_a !== 4'h1) $display("FAIL rise_hold got=%h exp=1", deb_a); else n_pass++;
  endtask

  task automatic test_steps();
    for (int v = 2; v <= 14; v++) begin
      src_a = 4'(v);
      for (int n = 0; n < 2 * MAX_A + S; n++) begin
        tick();
        n_checks++;
        if (deb_a !== exp_a) $display("FAIL steps v=%0d n=%0d got=%h exp=%h", v, n, deb_a, exp_a);
        else n_pass++;
      end
      n_checks++;
      if (deb_a !== 4'(v)) $display("FAIL steps_final got=%h exp=%h", deb_a, 4'(v));
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] vals [4] = '{4'hF, 4'h1, 4'h3, 4'hE};
    int           lens [4] = '{2, 4, 20, MAX_A + 8};
    for (int p = 0; p < 4; p++) begin
      src_a = vals[p];
      for (int n = 0; n < lens[p]; n++) begin
        tick();
        n_checks++;
        if (deb_a !== 4'hE || deb_a !== exp_a)
          $display("FAIL glitch p=%0d n=%0d got=%h exp=e model=%h", p, n, deb_a, exp_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_short_runs();
    logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int   rise = 0;
    for (int n = 1; n <= 8 + S + 12; n++) begin
      src_b = (n <= 8) ? pat[n-1] : 1'b0;
      tick();
      if (deb_b === 1'b1 && rise == 0) rise = n;
      n_checks++;
      if (deb_b !== exp_b) $display("FAIL short n=%0d got=%h exp=%h", n, deb_b, exp_b);
      else n_pass++;
    end
    n_checks++;
    if (rise != 8 + S) $display("FAIL short_rise got=%0d exp=%0d", rise, 8 + S);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    src_a = 4'hF;
    for (int n = 0; n < 10; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (deb_a !== 4'h0) $display("FAIL reset_mid_out got=%h exp=0", deb_a); else n_pass++;
    for (int n = 1; n <= 2 * MAX_A + S; n++) begin
      tick();
      if (deb_a === 4'hF && lat == 0) lat = n;
      n_checks++;
      if (deb_a !== exp_a) $display("FAIL reset_mid n=%0d got=%h exp=%h", n, deb_a, exp_a);
      else n_pass++;
    end
    n_checks++;
    if (lat != S + MAX_A) $display("FAIL reset_mid_latency got=%0d exp=%0d", lat, S + MAX_A);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 60; seg++) begin
      int len = $urandom_range(1, MAX_A + 8);
      src_a = 4'($urandom);
      src_b = 1'($urandom);
      for (int n = 0; n < len; n++) begin
        tick();
        n_checks++;
        if ({deb_a, deb_b} !== {exp_a, exp_b})
          $display("FAIL random seg=%0d n=%0d got=%h exp=%h", seg, n, {deb_a, deb_b}, {exp_a, exp_b});
        else n_pass++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < W; i++) start_a[i] = -1;
    reset = 1'b1;
    src_a = '0;
    src_b = '0;
    tick();
    tick();
    test_reset();
    test_rise_latency();
    test_steps();
    test_glitch();
    test_short_runs();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
